// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters; registered grant/start/ready.
// Optional tag mode (define UART_ARB_TAG_EN) prefixes each payload with the byte 'A'+grant_id.
module uart_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [7:0]               uart_byte,
  output logic                     uart_start,
  input  logic                     uart_done
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT      = 3'd2
`ifdef UART_ARB_TAG_EN
    ,
    TAG_START = 3'd3,
    TAG_WAIT  = 3'd4
`endif
  } state_t;

`ifdef UART_ARB_TAG_EN
  localparam logic [7:0] TAG_BASE = 8'h41;
`endif

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gid;
  logic [N_REQ-1:0] r_ready;
  logic             r_start;
  logic             r_busy;
  logic [7:0]       r_byte;
`ifdef UART_ARB_TAG_EN
  logic [7:0]       r_payload;
`endif

  logic             w_any;
  logic [IW-1:0]    w_win;
  logic [N_REQ-1:0] w_onehot;
  logic [7:0]       w_win_dat;

  // (base + ofs) mod N_REQ, so non-power-of-two N_REQ wraps correctly.
  function automatic logic [IW-1:0] f_rr(input logic [IW-1:0] base, input int ofs);
    int sum;
    sum = (int'(base) + ofs) % N_REQ;
    return sum[IW-1:0];
  endfunction

  // Scan from the lowest-priority offset down so the nearest requester to r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[f_rr(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = f_rr(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_onehot[w_win] = 1'b1;
    w_win_dat = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == IW'(k)) begin
        w_win_dat = req_data[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gid     <= '0;
      r_ready   <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_byte    <= 8'h00;
`ifdef UART_ARB_TAG_EN
      r_payload <= 8'h00;
`endif
    end else begin
      r_ready <= '0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gid   <= w_win;
            r_ptr   <= f_rr(w_win, 1);
            r_ready <= w_onehot;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
`ifdef UART_ARB_TAG_EN
            r_payload <= w_win_dat;
            r_byte    <= TAG_BASE + 8'(w_win);
            r_state   <= TAG_START;
`else
            r_byte  <= w_win_dat;
            r_state <= START;
`endif
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          if (uart_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG_START: r_state <= TAG_WAIT;
        // Tag finished: launch the payload without dropping busy.
        TAG_WAIT: begin
          if (uart_done) begin
            r_byte  <= r_payload;
            r_start <= 1'b1;
            r_state <= START;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign grant_id   = r_gid;
  assign busy       = r_busy;
  assign uart_byte  = r_byte;
  assign uart_start = r_start;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4); also builds with UART_ARB_TAG_EN for the tag sequence.
module tb_uart_tx_arbiter;

  localparam int N = 4;
`ifdef UART_ARB_TAG_EN
  localparam int SPG = 2;
`else
  localparam int SPG = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic [7:0]     uart_byte;
  logic           uart_start;
  logic           uart_done;
  logic           done_auto = 1'b0;
  logic           done_man = 1'b0;

  assign uart_done = done_auto | done_man;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_ready = 0;
  logic [1:0] gnt_q[$];
  logic [3:0] rdy_q[$];
  logic [7:0] byte_q[$];
  bit auto_en = 1'b0;
  int done_dly = 5;
  int dcnt = 0;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
    .uart_byte(uart_byte), .uart_start(uart_start), .uart_done(uart_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (uart_start) begin
      n_start++;
      byte_q.push_back(uart_byte);
    end
    if (|req_ready) begin
      n_ready++;
      gnt_q.push_back(grant_id);
      rdy_q.push_back(req_ready);
    end
  end

  // Transmitter model: done pulse done_dly cycles after each observed start.
  always @(negedge clk) begin
    done_auto = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) done_auto = 1'b1;
    end
    if (auto_en && uart_start) dcnt = done_dly;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic complete_xfer();
`ifdef UART_ARB_TAG_EN
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    repeat (3) @(negedge clk);
`endif
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (uart_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", uart_start); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (uart_byte !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %h want 00", uart_byte); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int s0, r0;
    do_reset();
    auto_en = 1'b0;
    s0 = n_start; r0 = n_ready;
    req_data[23:16] = 8'h30;
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    n_cmp++; if (uart_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", uart_start); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (uart_byte !== 8'h30) begin n_err++; $display("FAIL single_byte: got %h want 30", uart_byte); end
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_gid: got %0d want 2", grant_id); end
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (uart_start !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL single_pulse: start %b ready %b want 0 0000", uart_start, req_ready); end
    repeat (38) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || uart_byte !== 8'h30) begin n_err++; $display("FAIL single_hold: busy %b byte %h want 1 30", busy, uart_byte); end
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_start - s0 !== 1) begin n_err++; $display("FAIL single_nstart: got %0d want 1", n_start - s0); end
    n_cmp++; if (n_ready - r0 !== 1) begin n_err++; $display("FAIL single_nready: got %0d want 1", n_ready - r0); end
  endtask

  task automatic run_rr(input logic [3:0] vld, input int ngr, input int exp_id[8], input string nm);
    int g0, b0;
    logic [7:0] eb;
    do_reset();
    auto_en = 1'b1;
    g0 = gnt_q.size(); b0 = byte_q.size();
    req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    req_valid = vld;
    for (int c = 0; c < 3000 && gnt_q.size() - g0 < ngr; c++) @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 300 && busy; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    auto_en = 1'b0;
    n_cmp++; if (gnt_q.size() - g0 != ngr) begin n_err++; $display("FAIL %s_count: got %0d want %0d", nm, gnt_q.size() - g0, ngr); end
    n_cmp++; if (byte_q.size() - b0 != ngr * SPG) begin n_err++; $display("FAIL %s_bytes: got %0d want %0d", nm, byte_q.size() - b0, ngr * SPG); end
    for (int i = 0; i < ngr; i++) begin
      if (gnt_q.size() > g0 + i) begin
        n_cmp++; if (gnt_q[g0+i] !== 2'(exp_id[i])) begin n_err++; $display("FAIL %s_gid[%0d]: got %0d want %0d", nm, i, gnt_q[g0+i], exp_id[i]); end
        n_cmp++; if (rdy_q[g0+i] !== 4'(1 << exp_id[i])) begin n_err++; $display("FAIL %s_ready[%0d]: got %b want onehot %0d", nm, i, rdy_q[g0+i], exp_id[i]); end
      end
      for (int j = 0; j < SPG; j++) begin
        eb = (SPG == 2 && j == 0) ? 8'(8'h41 + exp_id[i]) : 8'(8'h30 + exp_id[i]);
        if (byte_q.size() > b0 + i * SPG + j) begin
          n_cmp++; if (byte_q[b0+i*SPG+j] !== eb) begin n_err++; $display("FAIL %s_byte[%0d.%0d]: got %h want %h", nm, i, j, byte_q[b0+i*SPG+j], eb); end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int e[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_rr(4'b1111, 8, e, "rr");
  endtask

  task automatic test_rr_skip();
    int e[8] = '{1, 3, 1, 0, 0, 0, 0, 0};
    run_rr(4'b1010, 3, e, "skip");
  endtask

  task automatic test_spurious();
    int s0, r0;
    logic [7:0] eb;
`ifdef UART_ARB_TAG_EN
    eb = 8'h41;
`else
    eb = 8'h5A;
`endif
    do_reset();
    auto_en = 1'b0;
    s0 = n_start; r0 = n_ready;
    @(negedge clk);
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || n_start != s0 || n_ready != r0) begin n_err++; $display("FAIL spur_idle: busy %b starts %0d readies %0d want 0 0 0", busy, n_start - s0, n_ready - r0); end
    req_data[7:0] = 8'h5A;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    req_data[31:24] = 8'hC3;
    req_valid = 4'b1000;
    repeat (4) @(negedge clk);
    req_valid = 4'b0000;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL spur_busy: got %b want 1", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL spur_gid: got %0d want 0", grant_id); end
    n_cmp++; if (uart_byte !== eb) begin n_err++; $display("FAIL spur_byte: got %h want %h", uart_byte, eb); end
    n_cmp++; if (n_ready - r0 != 1 || n_start - s0 != 1) begin n_err++; $display("FAIL spur_wait: readies %0d starts %0d want 1 1", n_ready - r0, n_start - s0); end
    complete_xfer();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL spur_end_busy: got %b want 0", busy); end
    n_cmp++; if (n_start - s0 != SPG || n_ready - r0 != 1) begin n_err++; $display("FAIL spur_end: starts %0d readies %0d want %0d 1", n_start - s0, n_ready - r0, SPG); end
  endtask

  task automatic test_reset_mid();
    int s1, r1;
    do_reset();
    auto_en = 1'b0;
    req_data[23:16] = 8'h52;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000 || uart_start !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_ctl: ready %b start %b busy %b want 0000 0 0", req_ready, uart_start, busy); end
    n_cmp++; if (uart_byte !== 8'h00 || grant_id !== 2'd0) begin n_err++; $display("FAIL rmid_dat: byte %h gid %0d want 00 0", uart_byte, grant_id); end
    @(negedge clk);
    rst = 1'b0;
    s1 = n_start; r1 = n_ready;
    repeat (4) @(negedge clk);
    n_cmp++; if (n_start != s1 || n_ready != r1 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_quiet: starts %0d readies %0d busy %b want 0 0 0", n_start - s1, n_ready - r1, busy); end
    req_data[23:16] = 8'h77;
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100 || grant_id !== 2'd2 || uart_start !== 1'b1) begin n_err++; $display("FAIL rmid_regrant: ready %b gid %0d start %b want 0100 2 1", req_ready, grant_id, uart_start); end
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (uart_start !== 1'b0) begin n_err++; $display("FAIL rmid_pulse: got %b want 0", uart_start); end
    complete_xfer();
    repeat (2) @(negedge clk);
    n_cmp++; if (n_start - s1 != SPG || n_ready - r1 != 1 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_end: starts %0d readies %0d busy %b want %0d 1 0", n_start - s1, n_ready - r1, busy, SPG); end
  endtask

`ifdef UART_ARB_TAG_EN
  task automatic test_tag();
    int s0, r0, low;
    do_reset();
    auto_en = 1'b0;
    s0 = n_start; r0 = n_ready; low = 0;
    req_data[23:16] = 8'h30;
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (uart_start !== 1'b1 || uart_byte !== 8'h43) begin n_err++; $display("FAIL tag_first: start %b byte %h want 1 43", uart_start, uart_byte); end
    n_cmp++; if (req_ready !== 4'b0100 || busy !== 1'b1) begin n_err++; $display("FAIL tag_ready: ready %b busy %b want 0100 1", req_ready, busy); end
    req_valid = 4'b0000;
    repeat (5) begin @(negedge clk); if (!busy) low++; end
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    n_cmp++; if (uart_start !== 1'b1 || uart_byte !== 8'h30) begin n_err++; $display("FAIL tag_payload: start %b byte %h want 1 30", uart_start, uart_byte); end
    n_cmp++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL tag_payload_ctl: ready %b busy %b want 0000 1", req_ready, busy); end
    repeat (5) begin @(negedge clk); if (!busy) low++; end
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tag_end_busy: got %b want 0", busy); end
    n_cmp++; if (low != 0) begin n_err++; $display("FAIL tag_busy_gap: got %0d low cycles want 0", low); end
    n_cmp++; if (n_start - s0 != 2 || n_ready - r0 != 1) begin n_err++; $display("FAIL tag_counts: starts %0d readies %0d want 2 1", n_start - s0, n_ready - r0); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef UART_ARB_TAG_EN
    test_single();
`endif
    test_round_robin();
    test_rr_skip();
    test_spurious();
    test_reset_mid();
`ifdef UART_ARB_TAG_EN
    test_tag();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of byte requesters sharing one uart_tx (legal range 2..8).
REQ-002 The block SHALL have port clk  input  1  single clock for all logic.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid  input  N_REQ  per-requester byte-available flag.
REQ-005 The block SHALL have port req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-006 The block SHALL have port req_ready  output  N_REQ  one-cycle accept pulse to the granted requester.
REQ-007 The block SHALL have port grant_id  output  clog2(N_REQ)  index of the current owner; valid while busy=1.
REQ-008 The block SHALL have port busy  output  1  high from the grant until the transmitter reports done.
REQ-009 The block SHALL have port uart_byte  output  8  byte to the uart_tx tx_byte input.
REQ-010 The block SHALL have port uart_start  output  1  one-cycle start pulse to the uart_tx start_send input.
REQ-011 The block SHALL have port uart_done  input  1  one-cycle completion pulse from uart_tx after the stop bit.

Function
REQ-012 The block SHALL implement the states IDLE, START, WAIT, plus TAG_START and TAG_WAIT when the tag feature is compiled in.
REQ-013 In IDLE, the block SHALL grant the first asserted req_valid in round-robin order, starting at (last_grant+1) mod N_REQ.
REQ-014 On a grant in cycle N, the block SHALL capture req_data of the winner and grant_id at the end of cycle N.
REQ-015 On a grant in cycle N, the block SHALL drive req_ready[grant_id]=1, uart_start=1 and busy=1 in cycle N+1 only (registered outputs), then enter WAIT.
REQ-016 The block SHALL hold uart_byte and grant_id stable from the start pulse until uart_done is seen.
REQ-017 In WAIT, uart_done SHALL return the block to IDLE in the next cycle with busy=0, so that the earliest next uart_start is two cycles after uart_done.
REQ-018 The block SHALL ignore req_valid outside IDLE, and SHALL ignore uart_done outside WAIT and TAG_WAIT.
REQ-019 Requesters SHALL hold req_valid and req_data until req_ready; the byte captured at grant SHALL be sent even if valid drops afterwards.
REQ-020 The block SHALL assert at most one req_ready bit in any cycle, and SHALL assert each req_ready for exactly one cycle per accepted byte.
REQ-021 The round-robin pointer SHALL wrap from N_REQ-1 to 0.
REQ-022 A single requester held valid continuously SHALL be granted once per transmitted byte, without starvation of others.
REQ-023 The block SHALL NOT pulse uart_start while busy, except for the payload start in tag mode.

Reset
REQ-024 While rst=1 at a clk edge, the block SHALL enter IDLE with req_ready=0, uart_start=0, busy=0, uart_byte=8'h00, grant_id=0, and the pointer set so that requester 0 has the highest priority.
REQ-025 A reset during START, WAIT or a tag state SHALL abandon the transfer without issuing req_ready or uart_start afterwards; the in-flight byte is lost.

Configuration
REQ-026 With macro UART_ARB_TAG_EN defined, each grant SHALL first send the tag byte 8'h41+grant_id ('A'+id), following the sequence TAG_START, TAG_WAIT, then START and WAIT for the payload.
REQ-027 With UART_ARB_TAG_EN defined, req_ready SHALL pulse with the tag uart_start, and busy SHALL remain high across both bytes.
REQ-028 Without UART_ARB_TAG_EN, no tag states or logic SHALL exist, and each grant SHALL send exactly one byte.

Verification
REQ-029 The bench SHALL drive single request req_valid=4'b0100, data 8'h30, done returned after 40 cycles -> req_ready=4'b0100 one cycle after the grant, uart_byte=8'h30, one uart_start, busy falls one cycle after uart_done.
REQ-030 The bench SHALL hold all four requesters valid after reset, through 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-031 The bench SHALL assert requesters 1 and 3 while the block grants 1 -> the next grant after 1 is 3, then 1.
REQ-032 The bench SHALL issue a spurious uart_done in IDLE and a req_valid change during WAIT -> no state change, no extra req_ready or uart_start.
REQ-033 The bench SHALL assert rst in WAIT, then re-request requester 2 -> all outputs zero during reset, fresh grant to 2 with a single start pulse.
REQ-034 The bench SHALL build with UART_ARB_TAG_EN and requester 2 sending 8'h30 -> uart_byte sequence 8'h43 then 8'h30, two uart_start pulses, one req_ready, busy continuous.
